ntt_tw_mul: RTL and testbench
=============================

Name: ntt_tw_mul

Overview:
- Pipelined twiddle-multiply stage placed directly upstream of the NTT butterfly PE.
- Takes a (top, bot, twiddle) beat, computes bot*w mod q by Barrett reduction, and delays top by the same latency.
- Presents an aligned (top, bot') pair to the butterfly's data_top_i/data_bot_i inputs.
- Valid/ready handshake on both sides; stalls the whole pipe on back-pressure.

Parameters:
- DATA_W, `DATA_SIZE_ARB, operand/modulus width N.
- LAT, 4, fixed pipeline depth in accepted-beat cycles. Localparam; not overridable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; clears all state while low.
- q  in  DATA_W  modulus; requires 2^(N-1) <= q < 2^N.
- mu  in  DATA_W+1  Barrett constant floor(2^(2N)/q), supplied by host.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat this cycle.
- top_i  in  DATA_W  butterfly top operand; passed through, not modified.
- bot_i  in  DATA_W  butterfly bottom operand, < q.
- tw_i  in  DATA_W  twiddle factor, < q.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- top_o  out  DATA_W  delayed top_i, feeds the butterfly data_top_i.
- bot_o  out  DATA_W  (bot_i*tw_i) mod q, feeds the butterfly data_bot_i.
- busy_o  out  1  any valid beat in the pipe (OR of stage valids).

Behaviour:
- Reset (reset low, asynchronous): all stage valids = 0, out_valid = 0, top_o = 0, bot_o = 0, busy_o = 0. Data registers are also cleared to 0.
- Advance enable: en = !out_valid | out_ready. in_ready = en, combinational.
- When en = 1, every stage register shifts one position and the stage valids shift with them. When en = 0, all registers hold.
- An input beat is accepted when in_valid & in_ready. Its result appears with out_valid = 1 exactly 4 cycles later if the pipe never stalls. Throughput: 1 beat/cycle.
- S1: P = bot_i*tw_i (2N bits). top_i is registered alongside.
- S2: t = ((P >> (N-1)) * mu) >> (N+1) (N+1 bits). P and top are carried forward.
- S3: r = P[N+1:0] - (t*q)[N+1:0] (N+2 bits, unsigned). Guaranteed 0 <= r < 3q.
- S4: if r >= 2q then r - 2q; else if r >= q then r - q; else r. The result is registered into bot_o, and top is registered into top_o.
- Bubbles: a stage with valid = 0 still shifts. Its data is don't-care but must never raise out_valid.
- Holding rule: while out_valid & !out_ready, top_o and bot_o are held stable.
- Simultaneous events: out_ready rising in the same cycle as in_valid lets a new beat enter while the held beat leaves. No beat is lost or duplicated.
- q and mu are quasi-static: they may change only while busy_o = 0. Behaviour is undefined otherwise.
- Reset mid-operation flushes all in-flight beats; no output is produced for them.
- Edge values: bot_i = 0 or tw_i = 0 gives 0. bot_i = tw_i = q-1 gives 1.

Optional Feature:
- Macro: NTT_TWMUL_RANGE_CHECK_EN.
- When defined: extra output port err_o (1 bit). err_o is a sticky flag, set one cycle after any accepted beat with bot_i >= q or tw_i >= q. It is cleared only by reset (reset value 0). The data path is unaffected.
- When undefined: err_o is absent and no comparison logic is built.

Decomposition:
- Package ntt_pkg holds:
  - the DATA_W constant derived from `DATA_SIZE_ARB;
  - localparam TW_MUL_LAT = 4;
  - typedef data_t = logic [DATA_W-1:0];
  - typedef prod_t = logic [2*DATA_W-1:0].
- One sub-module, ntt_barrett_red, implements S2-S4 (reduction pipeline with stage enable and valid chain).
- The top level holds S1, the top-delay line, the handshake and the optional check.

Test Plan (DATA_W = 14, q = 12289, mu = 21843):
- Reset release, out_ready = 1, single beat top = 77, bot = 100, tw = 200 -> 4 cycles later out_valid = 1, top_o = 77, bot_o = 7711; out_valid = 0 next cycle.
- Boundary operands bot = tw = 12288 -> bot_o = 1. bot = 0, tw = 12288 -> bot_o = 0. bot = 5, tw = 3 -> bot_o = 15.
- Back-to-back stream of 16 random beats with out_ready = 1 -> 16 consecutive output cycles, in order, matching a reference model of (bot*tw) % q; in_ready stays 1.
- out_ready = 0 for 6 cycles with continuous in_valid -> in_ready drops while out_valid is held; top_o/bot_o stay stable; no loss or duplication after release; busy_o = 1 throughout.
- Assert reset low mid-stream with 3 beats in flight -> outputs 0 immediately (asynchronous); after release no stale out_valid appears.
- With NTT_TWMUL_RANGE_CHECK_EN: a beat with tw = 12289 -> err_o = 1 next cycle and remains 1 until reset.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared widths and types for the NTT datapath.
// Operand width N follows `DATA_SIZE_ARB (14 when the build does not define it).
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 14
`endif

package ntt_pkg;

   localparam int DATA_W     = `DATA_SIZE_ARB;
   localparam int TW_MUL_LAT = 4;

   typedef logic [DATA_W-1:0]   data_t;
   typedef logic [2*DATA_W-1:0] prod_t;

endpackage

// File: rtl/ntt_barrett_red.sv
// Barrett reduction of a 2N-bit product modulo q: quotient estimate, remainder, final correction.
// Three register stages sharing one advance enable, with a valid bit travelling alongside.
module ntt_barrett_red
   import ntt_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic [DATA_W-1:0]     q,
   input  logic [DATA_W:0]       mu,
   input  logic                  valid_in,
   input  logic [2*DATA_W-1:0]   prod_in,
   output logic                  valid_out,
   output logic [DATA_W-1:0]     res_out,
   output logic                  busy
);

   localparam int W_EST = 2*DATA_W + 2;
   localparam int W_RED = DATA_W + 2;

   logic [W_EST-1:0]  est_full;
   logic [DATA_W:0]   t_c;
   logic              unused_est_lsb;

   logic              v2;
   logic [DATA_W:0]   t2;
   logic [W_RED-1:0]  p2;

   logic [W_RED-1:0]  tq_lo;
   logic [W_RED-1:0]  r_c;
   logic              v3;
   logic [W_RED-1:0]  r3;

   logic [W_RED-1:0]  q1_x;
   logic [W_RED-1:0]  q2_x;
   logic [W_RED-1:0]  sub_c;
   logic              unused_sub_msb;

   // Quotient estimate t = ((P >> (N-1)) * mu) >> (N+1); the low product bits only feed the shift.
   assign est_full       = W_EST'(prod_in[2*DATA_W-1:DATA_W-1]) * W_EST'(mu);
   assign t_c            = est_full[W_EST-1:DATA_W+1];
   assign unused_est_lsb = ^est_full[DATA_W:0];

   // The true remainder is below 3q < 2^(N+2), so only the low N+2 bits of P and t*q matter.
   assign tq_lo = W_RED'(t2) * W_RED'(q);
   assign r_c   = p2 - tq_lo;

   always_comb begin
      q1_x = {2'b00, q};
      q2_x = {1'b0, q, 1'b0};
      if (r3 >= q2_x) begin
         sub_c = r3 - q2_x;
      end else if (r3 >= q1_x) begin
         sub_c = r3 - q1_x;
      end else begin
         sub_c = r3;
      end
   end

   assign unused_sub_msb = ^sub_c[W_RED-1:DATA_W];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v2        <= 1'b0;
         t2        <= '0;
         p2        <= '0;
         v3        <= 1'b0;
         r3        <= '0;
         valid_out <= 1'b0;
         res_out   <= '0;
      end else if (en) begin
         v2        <= valid_in;
         t2        <= t_c;
         p2        <= prod_in[W_RED-1:0];
         v3        <= v2;
         r3        <= r_c;
         valid_out <= v3;
         res_out   <= sub_c[DATA_W-1:0];
      end
   end

   assign busy = v2 | v3 | valid_out;

endmodule

// File: rtl/ntt_tw_mul.sv
// Twiddle-multiply stage ahead of the butterfly PE: bot*tw mod q, with top delayed to stay aligned.
// Optional sticky operand range flag err_o when NTT_TWMUL_RANGE_CHECK_EN is defined.
module ntt_tw_mul
   import ntt_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic [DATA_W-1:0]   q,
   input  logic [DATA_W:0]     mu,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_W-1:0]   top_i,
   input  logic [DATA_W-1:0]   bot_i,
   input  logic [DATA_W-1:0]   tw_i,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   top_o,
   output logic [DATA_W-1:0]   bot_o,
   output logic                busy_o
`ifdef NTT_TWMUL_RANGE_CHECK_EN
   ,
   output logic                err_o
`endif
);

   localparam int LAT = TW_MUL_LAT;
   localparam int W_P = 2*DATA_W;

   logic                en;
   logic                v1;
   logic [W_P-1:0]      p1;
   logic [DATA_W-1:0]   top_pipe [LAT];
   logic                red_busy;

   // One enable freezes every stage together, so a held output never gets overwritten.
   assign en       = !out_valid | out_ready;
   assign in_ready = en;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v1 <= 1'b0;
         p1 <= '0;
         for (int i = 0; i < LAT; i++) begin
            top_pipe[i] <= '0;
         end
      end else if (en) begin
         v1          <= in_valid;
         p1          <= W_P'(bot_i) * W_P'(tw_i);
         top_pipe[0] <= top_i;
         for (int i = 1; i < LAT; i++) begin
            top_pipe[i] <= top_pipe[i-1];
         end
      end
   end

   assign top_o = top_pipe[LAT-1];

   ntt_barrett_red u_red (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .q         (q),
      .mu        (mu),
      .valid_in  (v1),
      .prod_in   (p1),
      .valid_out (out_valid),
      .res_out   (bot_o),
      .busy      (red_busy)
   );

   assign busy_o = v1 | red_busy;

`ifdef NTT_TWMUL_RANGE_CHECK_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_o <= 1'b0;
      end else if (in_valid && en && ((bot_i >= q) || (tw_i >= q))) begin
         err_o <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_ntt_tw_mul.sv
// Directed bench for ntt_tw_mul with q = 12289, mu = 21843, N = 14.
module tb_ntt_tw_mul;
   import ntt_pkg::*;

   localparam int Q  = 12289;
   localparam int MU = 21843;

   logic                clk = 1'b0;
   logic                reset;
   logic [DATA_W-1:0]   q;
   logic [DATA_W:0]     mu;
   logic                in_valid;
   logic                in_ready;
   logic [DATA_W-1:0]   top_i;
   logic [DATA_W-1:0]   bot_i;
   logic [DATA_W-1:0]   tw_i;
   logic                out_valid;
   logic                out_ready;
   logic [DATA_W-1:0]   top_o;
   logic [DATA_W-1:0]   bot_o;
   logic                busy_o;
`ifdef NTT_TWMUL_RANGE_CHECK_EN
   logic                err_o;
`endif

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   ntt_tw_mul dut (
      .clk       (clk),
      .reset     (reset),
      .q         (q),
      .mu        (mu),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .top_i     (top_i),
      .bot_i     (bot_i),
      .tw_i      (tw_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .top_o     (top_o),
      .bot_o     (bot_o),
      .busy_o    (busy_o)
`ifdef NTT_TWMUL_RANGE_CHECK_EN
      ,
      .err_o     (err_o)
`endif
   );

   task automatic test_reset();
      reset     = 1'b0;
      q         = DATA_W'(Q);
      mu        = (DATA_W+1)'(MU);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      top_i     = '0;
      bot_i     = '0;
      tw_i      = '0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if (out_valid !== 1'b0) begin n_miss++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_vec++;
      if (top_o !== '0) begin n_miss++; $display("FAIL reset_top_o got %0d want 0", top_o); end
      n_vec++;
      if (bot_o !== '0) begin n_miss++; $display("FAIL reset_bot_o got %0d want 0", bot_o); end
      n_vec++;
      if (busy_o !== 1'b0) begin n_miss++; $display("FAIL reset_busy got %b want 0", busy_o); end
      n_vec++;
      if (in_ready !== 1'b1) begin n_miss++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      reset = 1'b1;
   endtask

   task automatic run_beat(input logic [DATA_W-1:0] t, input logic [DATA_W-1:0] b,
                           input logic [DATA_W-1:0] w, input logic [DATA_W-1:0] exp_b,
                           input string name);
      int n;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      top_i    = t;
      bot_i    = b;
      tw_i     = w;
      n_vec++;
      if (in_ready !== 1'b1) begin n_miss++; $display("FAIL %s_in_ready got %b want 1", name, in_ready); end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 12) begin
         @(posedge clk);
         #1;
         n++;
      end
      n_vec++;
      if (n !== 4) begin n_miss++; $display("FAIL %s_latency got %0d want 4", name, n); end
      n_vec++;
      if (top_o !== t) begin n_miss++; $display("FAIL %s_top got %0d want %0d", name, top_o, t); end
      n_vec++;
      if (bot_o !== exp_b) begin n_miss++; $display("FAIL %s_bot got %0d want %0d", name, bot_o, exp_b); end
      @(posedge clk);
      #1;
      n_vec++;
      if (out_valid !== 1'b0) begin n_miss++; $display("FAIL %s_one_shot got %b want 0", name, out_valid); end
   endtask

   task automatic test_single();
      run_beat(14'd77, 14'd100, 14'd200, 14'd7711, "single");
   endtask

   task automatic test_edges();
      run_beat(14'd1, 14'd12288, 14'd12288, 14'd1, "max_max");
      run_beat(14'd2, 14'd0, 14'd12288, 14'd0, "zero_bot");
      run_beat(14'd3, 14'd5, 14'd3, 14'd15, "small");
      run_beat(14'd4, 14'd12288, 14'd0, 14'd0, "zero_tw");
   endtask

   task automatic test_stream(input int n, input int stall_at, input int stall_len, input string name);
      logic [DATA_W-1:0] s_top [16];
      logic [DATA_W-1:0] s_bot [16];
      logic [DATA_W-1:0] s_tw  [16];
      logic [DATA_W-1:0] e_bot [16];
      int   sent  = 0;
      int   rd    = 0;
      int   k     = 0;
      int   first = -1;
      int   last  = -1;
      logic held  = 1'b0;
      logic stall;
      logic [DATA_W-1:0] h_top;
      logic [DATA_W-1:0] h_bot;
      for (int i = 0; i < n; i++) begin
         s_top[i] = DATA_W'($urandom_range(0, 16383));
         s_bot[i] = DATA_W'($urandom_range(0, Q-1));
         s_tw[i]  = DATA_W'($urandom_range(0, Q-1));
         e_bot[i] = DATA_W'((int'(s_bot[i]) * int'(s_tw[i])) % Q);
      end
      while (rd < n && k < 200) begin
         @(posedge clk);
         #1;
         stall     = (k >= stall_at) && (k < stall_at + stall_len);
         out_ready = !stall;
         #1;
         if (held) begin
            n_vec++;
            if (top_o !== h_top || bot_o !== h_bot) begin
               n_miss++;
               $display("FAIL %s_hold got %0d/%0d want %0d/%0d", name, top_o, bot_o, h_top, h_bot);
            end
         end
         held = 1'b0;
         if (out_valid && out_ready) begin
            n_vec++;
            if (top_o !== s_top[rd] || bot_o !== e_bot[rd]) begin
               n_miss++;
               $display("FAIL %s_beat%0d got %0d/%0d want %0d/%0d", name, rd, top_o, bot_o, s_top[rd], e_bot[rd]);
            end
            if (first < 0) first = k;
            last = k;
            rd++;
         end else if (out_valid) begin
            n_vec++;
            if (in_ready !== 1'b0) begin n_miss++; $display("FAIL %s_stall_in_ready got %b want 0", name, in_ready); end
            held  = 1'b1;
            h_top = top_o;
            h_bot = bot_o;
         end
         if (stall) begin
            n_vec++;
            if (busy_o !== 1'b1) begin n_miss++; $display("FAIL %s_busy got %b want 1", name, busy_o); end
         end else begin
            n_vec++;
            if (in_ready !== 1'b1) begin n_miss++; $display("FAIL %s_in_ready got %b want 1", name, in_ready); end
         end
         if (sent < n) begin
            in_valid = 1'b1;
            top_i    = s_top[sent];
            bot_i    = s_bot[sent];
            tw_i     = s_tw[sent];
            if (in_ready) sent++;
         end else begin
            in_valid = 1'b0;
         end
         k++;
      end
      in_valid = 1'b0;
      n_vec++;
      if (rd !== n) begin n_miss++; $display("FAIL %s_timeout got %0d beats want %0d", name, rd, n); end
      n_vec++;
      if (last - first !== n - 1 + stall_len) begin
         n_miss++;
         $display("FAIL %s_gap_free got span %0d want %0d", name, last - first, n - 1 + stall_len);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if (out_valid !== 1'b0) begin n_miss++; $display("FAIL %s_no_extra got %b want 0", name, out_valid); end
   endtask

   task automatic test_back_to_back();
      test_stream(16, 1000, 0, "b2b");
   endtask

   task automatic test_stall();
      test_stream(16, 6, 6, "stall");
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b1;
         top_i    = DATA_W'(1000 + i);
         bot_i    = DATA_W'(100 + i);
         tw_i     = 14'd200;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n_vec++;
      if (out_valid !== 1'b1 || bot_o !== 14'd7911) begin
         n_miss++;
         $display("FAIL rstmid_pre got valid %b bot %0d want 1 7911", out_valid, bot_o);
      end
      n_vec++;
      if (busy_o !== 1'b1) begin n_miss++; $display("FAIL rstmid_pre_busy got %b want 1", busy_o); end
      #2;
      reset = 1'b0;
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || top_o !== '0 || bot_o !== '0 || busy_o !== 1'b0) begin
         n_miss++;
         $display("FAIL rstmid_async got v%b t%0d b%0d busy%b want all 0", out_valid, top_o, bot_o, busy_o);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         n_vec++;
         if (out_valid !== 1'b0 || busy_o !== 1'b0) begin
            n_miss++;
            $display("FAIL rstmid_stale cycle %0d got v%b busy%b want 0 0", i, out_valid, busy_o);
         end
      end
   endtask

`ifdef NTT_TWMUL_RANGE_CHECK_EN
   task automatic test_range_check();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      n_vec++;
      if (err_o !== 1'b0) begin n_miss++; $display("FAIL err_idle got %b want 0", err_o); end
      in_valid = 1'b1;
      top_i    = 14'd9;
      bot_i    = 14'd5;
      tw_i     = 14'd12289;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n_vec++;
      if (err_o !== 1'b1) begin n_miss++; $display("FAIL err_set got %b want 1", err_o); end
      repeat (6) @(posedge clk);
      #1;
      n_vec++;
      if (err_o !== 1'b1) begin n_miss++; $display("FAIL err_sticky got %b want 1", err_o); end
      reset = 1'b0;
      #1;
      n_vec++;
      if (err_o !== 1'b0) begin n_miss++; $display("FAIL err_reset got %b want 0", err_o); end
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_edges();
      test_back_to_back();
      test_stall();
      test_reset_mid();
`ifdef NTT_TWMUL_RANGE_CHECK_EN
      test_range_check();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
